mem_load_store_unit: RTL and testbench

//  MEM-stage consumer of the EX operand path. Takes the effective address computed by the
//  ALU (lw/sw offset added), the store data and control, and runs a req/ack transaction
//  on the data-memory port. Generates byte enables and store-lane replication, extracts and

---
 rtl/mem_load_store_unit.sv | 172 +++++++++++++++++
 tb/tb_mem_load_store_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_load_store_unit.sv
// rtl/mem_load_store_unit.sv - MEM-stage load/store unit with req/ack data-memory port
module mem_load_store_unit #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [31:0]       ALU_Result_MEM,
  input  logic [31:0]       Write_Data_MEM,
  input  logic              MemRead_MEM,
  input  logic              MemWrite_MEM,
  input  logic [1:0]        Mem_Size_MEM,
  input  logic              Mem_Unsigned_MEM,
  output logic              Dmem_Req,
  output logic              Dmem_We,
  output logic [ADDR_W-1:0] Dmem_Addr,
  output logic [3:0]        Dmem_Be,
  output logic [31:0]       Dmem_Wdata,
  input  logic              Dmem_Ack,
  input  logic [31:0]       Dmem_Rdata,
  output logic              Stall_MEM,
  output logic [31:0]       Read_Data_MEM,
  output logic              Load_Valid_MEM,
  output logic              Misaligned_MEM,
  output logic              Bus_Error_MEM
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e            state_q, state_d;
  logic              req_q, req_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]        size_q, size_d, off_q, off_d;
  logic              uns_q, uns_d, load_valid_q, load_valid_d, bus_err_q, bus_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              access, misal, timeout_hit;
  logic [3:0]        be_new;
  logic [31:0]       wdata_new, rd_shift, load_ext;

  assign access = MemRead_MEM | MemWrite_MEM;
  assign misal  = ((Mem_Size_MEM == 2'b01) & ALU_Result_MEM[0]) |
                  (Mem_Size_MEM[1] & (ALU_Result_MEM[1:0] != 2'b00));

  always_comb begin
    be_new    = 4'b1111;
    wdata_new = Write_Data_MEM;
    case (Mem_Size_MEM)
      2'b00: begin
        be_new    = 4'b0001 << ALU_Result_MEM[1:0];
        wdata_new = {4{Write_Data_MEM[7:0]}};
      end
      2'b01: begin
        be_new    = ALU_Result_MEM[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{Write_Data_MEM[15:0]}};
      end
      default: ;
    endcase
  end

  // Extraction uses the latched offset/size, since the ack arrives after IDLE.
  assign rd_shift = Dmem_Rdata >> {off_q, 3'b000};

  always_comb begin
    load_ext = Dmem_Rdata;
    case (size_q)
      2'b00:   load_ext = {{24{rd_shift[7] & ~uns_q}}, rd_shift[7:0]};
      2'b01:   load_ext = {{16{rd_shift[15] & ~uns_q}}, rd_shift[15:0]};
      default: ;
    endcase
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (32'(cnt_q) == TIMEOUT_CYCLES - 1);

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    size_d       = size_q;
    off_d        = off_q;
    uns_d        = uns_q;
    cnt_d        = cnt_q;
    load_valid_d = 1'b0;
    bus_err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access && !misal) begin
          state_d = S_BUSY;
          req_d   = 1'b1;
          we_d    = MemWrite_MEM;
          addr_d  = {ALU_Result_MEM[ADDR_W-1:2], 2'b00};
          be_d    = be_new;
          wdata_d = wdata_new;
          size_d  = Mem_Size_MEM;
          off_d   = ALU_Result_MEM[1:0];
          uns_d   = Mem_Unsigned_MEM;
          cnt_d   = '0;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        // An ack in the same cycle as the timeout still completes the access.
        if (Dmem_Ack) begin
          req_d   = 1'b0;
          state_d = S_DONE;
          if (!we_q) begin
            rdata_d      = load_ext;
            load_valid_d = 1'b1;
          end
        end else if (timeout_hit) begin
          req_d     = 1'b0;
          bus_err_d = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      be_q         <= 4'b0000;
      wdata_q      <= 32'h0;
      rdata_q      <= 32'h0;
      size_q       <= 2'b00;
      off_q        <= 2'b00;
      uns_q        <= 1'b0;
      cnt_q        <= '0;
      load_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      size_q       <= size_d;
      off_q        <= off_d;
      uns_q        <= uns_d;
      cnt_q        <= cnt_d;
      load_valid_q <= load_valid_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign Dmem_Req       = req_q;
  assign Dmem_We        = we_q;
  assign Dmem_Addr      = addr_q;
  assign Dmem_Be        = be_q;
  assign Dmem_Wdata     = wdata_q;
  assign Read_Data_MEM  = rdata_q;
  assign Load_Valid_MEM = load_valid_q;
  assign Bus_Error_MEM  = bus_err_q;
  assign Stall_MEM      = ((state_q == S_IDLE) && access && !misal) || (state_q == S_BUSY);
  assign Misaligned_MEM = (state_q == S_IDLE) && access && misal;

endmodule

// File: tb/tb_mem_load_store_unit.sv
// tb/tb_mem_load_store_unit.sv - scoreboard bench for mem_load_store_unit
module tb_mem_load_store_unit;

  localparam int K_REQ = 0, K_LOAD = 1, K_BERR = 2, K_MISAL = 3;

  typedef struct {
    int          kind;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } exp_t;

  logic        Clk = 1'b0, Reset = 1'b1;
  logic [31:0] ALU_Result_MEM = '0, Write_Data_MEM = '0, Dmem_Rdata = '0;
  logic        MemRead_MEM = 1'b0, MemWrite_MEM = 1'b0, Mem_Unsigned_MEM = 1'b0, Dmem_Ack = 1'b0;
  logic [1:0]  Mem_Size_MEM = 2'b00;
  logic        Dmem_Req, Dmem_We, Stall_MEM, Load_Valid_MEM, Misaligned_MEM, Bus_Error_MEM;
  logic [31:0] Dmem_Addr, Dmem_Wdata, Read_Data_MEM;
  logic [3:0]  Dmem_Be;

  int   checks = 0, errors = 0;
  exp_t sb[$];
  logic req_prev = 1'b0;

  mem_load_store_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .Clk(Clk), .Reset(Reset), .ALU_Result_MEM(ALU_Result_MEM), .Write_Data_MEM(Write_Data_MEM),
    .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM), .Mem_Size_MEM(Mem_Size_MEM),
    .Mem_Unsigned_MEM(Mem_Unsigned_MEM), .Dmem_Req(Dmem_Req), .Dmem_We(Dmem_We),
    .Dmem_Addr(Dmem_Addr), .Dmem_Be(Dmem_Be), .Dmem_Wdata(Dmem_Wdata), .Dmem_Ack(Dmem_Ack),
    .Dmem_Rdata(Dmem_Rdata), .Stall_MEM(Stall_MEM), .Read_Data_MEM(Read_Data_MEM),
    .Load_Valid_MEM(Load_Valid_MEM), .Misaligned_MEM(Misaligned_MEM), .Bus_Error_MEM(Bus_Error_MEM)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pop_expect(input int kind, output exp_t e, output bit ok);
    ok = 1'b0;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d expected none", kind);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind) begin
        errors++;
        $display("FAIL event_kind: got %0d expected %0d", kind, e.kind);
      end else ok = 1'b1;
    end
  endtask

  // Monitor: every DUT-presented event is matched against the scoreboard queue.
  always @(negedge Clk) begin
    exp_t e;
    bit   ok;
    if (!Reset) begin
      if (Dmem_Req && !req_prev) begin
        pop_expect(K_REQ, e, ok);
        if (ok) begin
          chk("req_we", {31'b0, Dmem_We}, {31'b0, e.we});
          chk("req_addr", Dmem_Addr, e.addr);
          chk("req_be", {28'b0, Dmem_Be}, {28'b0, e.be});
          if (e.we) chk("req_wdata", Dmem_Wdata, e.data);
        end
      end
      if (Load_Valid_MEM) begin
        pop_expect(K_LOAD, e, ok);
        if (ok) chk("load_data", Read_Data_MEM, e.data);
      end
      if (Bus_Error_MEM) pop_expect(K_BERR, e, ok);
      if (Misaligned_MEM) pop_expect(K_MISAL, e, ok);
    end
    req_prev = Dmem_Req;
  end

  function automatic exp_t mk(int kind, logic we, logic [31:0] addr, logic [3:0] be, logic [31:0] data);
    exp_t e;
    e.kind = kind; e.we = we; e.addr = addr; e.be = be; e.data = data;
    return e;
  endfunction

  // ack_cyc: BUSY cycle index (0 = first) carrying the ack; -1 = never ack.
  task automatic run_access(input string name, input logic rd, input logic wr, input logic [1:0] sz,
                            input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                            input int ack_cyc, input logic [31:0] rdata,
                            input int exp_stall, input int exp_req);
    int stalls = 0;
    int reqs = 0;
    @(posedge Clk); #1;
    MemRead_MEM = rd; MemWrite_MEM = wr; Mem_Size_MEM = sz; Mem_Unsigned_MEM = uns;
    ALU_Result_MEM = addr; Write_Data_MEM = wd;
    for (int n = 0; n < 40; n++) begin
      Dmem_Ack   = (ack_cyc >= 0) && (n == ack_cyc + 1);
      Dmem_Rdata = Dmem_Ack ? rdata : 32'h5A5A_5A5A;
      @(negedge Clk);
      if (Dmem_Req) reqs++;
      if (Stall_MEM) stalls++;
      else break;
      @(posedge Clk); #1;
    end
    chk({name, "_stall"}, 32'(stalls), 32'(exp_stall));
    chk({name, "_req_cycles"}, 32'(reqs), 32'(exp_req));
    @(posedge Clk); #1;
    MemRead_MEM = 1'b0; MemWrite_MEM = 1'b0; Dmem_Ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst_req", {31'b0, Dmem_Req}, 32'h0);
    chk("rst_we", {31'b0, Dmem_We}, 32'h0);
    chk("rst_addr", Dmem_Addr, 32'h0);
    chk("rst_be", {28'b0, Dmem_Be}, 32'h0);
    chk("rst_wdata", Dmem_Wdata, 32'h0);
    chk("rst_rdata", Read_Data_MEM, 32'h0);
    chk("rst_flags", {29'b0, Load_Valid_MEM, Bus_Error_MEM, Stall_MEM}, 32'h0);
    @(posedge Clk); #1;
    Reset = 1'b0;

    // sw 0xDEADBEEF @0x100, ack in 2nd BUSY cycle
    sb.push_back(mk(K_REQ, 1'b1, 32'h100, 4'b1111, 32'hDEADBEEF));
    run_access("sw", 0, 1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 1, 32'h0, 3, 2);
    // lb @0x103
    sb.push_back(mk(K_REQ, 1'b0, 32'h100, 4'b1000, 32'h0));
    sb.push_back(mk(K_LOAD, 1'b0, 0, 0, 32'hFFFFFF80));
    run_access("lb", 1, 0, 2'b00, 0, 32'h103, 32'h0, 0, 32'h80112233, 2, 1);
    // lhu @0x102
    sb.push_back(mk(K_REQ, 1'b0, 32'h100, 4'b1100, 32'h0));
    sb.push_back(mk(K_LOAD, 1'b0, 0, 0, 32'h00008001));
    run_access("lhu", 1, 0, 2'b01, 1, 32'h102, 32'h0, 0, 32'h8001ABCD, 2, 1);
    // lw @0x101 misaligned
    sb.push_back(mk(K_MISAL, 1'b0, 0, 0, 0));
    run_access("lw_misal", 1, 0, 2'b10, 0, 32'h101, 32'h0, 0, 32'h0, 0, 0);
    // lw, no ack: 4-cycle timeout
    sb.push_back(mk(K_REQ, 1'b0, 32'h200, 4'b1111, 32'h0));
    sb.push_back(mk(K_BERR, 1'b0, 0, 0, 0));
    run_access("lw_timeout", 1, 0, 2'b10, 0, 32'h200, 32'h0, -1, 32'h0, 5, 4);
    // ack in the last BUSY cycle before timeout completes normally
    sb.push_back(mk(K_REQ, 1'b0, 32'h500, 4'b1111, 32'h0));
    sb.push_back(mk(K_LOAD, 1'b0, 0, 0, 32'h11112222));
    run_access("lw_late_ack", 1, 0, 2'b10, 0, 32'h500, 32'h0, 3, 32'h11112222, 5, 4);
    // sb 0x78 @0x42
    sb.push_back(mk(K_REQ, 1'b1, 32'h40, 4'b0100, 32'h78787878));
    run_access("sb", 0, 1, 2'b00, 0, 32'h42, 32'h12345678, 0, 32'h0, 2, 1);
    // sh 0x1234 @0x46, ack in 3rd BUSY cycle
    sb.push_back(mk(K_REQ, 1'b1, 32'h44, 4'b1100, 32'h12341234));
    run_access("sh", 0, 1, 2'b01, 0, 32'h46, 32'hCAFE1234, 2, 32'h0, 4, 3);
    // lh @0x204 sign-extended
    sb.push_back(mk(K_REQ, 1'b0, 32'h204, 4'b0011, 32'h0));
    sb.push_back(mk(K_LOAD, 1'b0, 0, 0, 32'hFFFFF00D));
    run_access("lh", 1, 0, 2'b01, 0, 32'h204, 32'h0, 0, 32'h1234F00D, 2, 1);
    // lbu @0x301
    sb.push_back(mk(K_REQ, 1'b0, 32'h300, 4'b0010, 32'h0));
    sb.push_back(mk(K_LOAD, 1'b0, 0, 0, 32'h000000AB));
    run_access("lbu", 1, 0, 2'b00, 1, 32'h301, 32'h0, 0, 32'h0000AB00, 2, 1);
    // lw @0x400, size 11 also means word
    sb.push_back(mk(K_REQ, 1'b0, 32'h400, 4'b1111, 32'h0));
    sb.push_back(mk(K_LOAD, 1'b0, 0, 0, 32'h89ABCDEF));
    run_access("lw", 1, 0, 2'b11, 1, 32'h400, 32'h0, 0, 32'h89ABCDEF, 2, 1);
    // sh @0x103 misaligned
    sb.push_back(mk(K_MISAL, 1'b0, 0, 0, 0));
    run_access("sh_misal", 0, 1, 2'b01, 0, 32'h103, 32'h0, 0, 32'h0, 0, 0);
    // read and write both set: store wins
    sb.push_back(mk(K_REQ, 1'b1, 32'h10, 4'b1111, 32'h0BADF00D));
    run_access("rw_both", 1, 1, 2'b10, 0, 32'h10, 32'h0BADF00D, 0, 32'hFFFFFFFF, 2, 1);

    // Stray ack while idle is ignored
    @(posedge Clk); #1;
    Dmem_Ack = 1'b1; Dmem_Rdata = 32'hFFFF0000;
    @(posedge Clk); #1;
    Dmem_Ack = 1'b0;
    @(negedge Clk);
    chk("idle_ack_req", {31'b0, Dmem_Req}, 32'h0);
    chk("idle_ack_rdata", Read_Data_MEM, 32'h89ABCDEF);

    // Reset asserted for one cycle mid-BUSY
    sb.push_back(mk(K_REQ, 1'b0, 32'h600, 4'b1111, 32'h0));
    @(posedge Clk); #1;
    MemRead_MEM = 1'b1; Mem_Size_MEM = 2'b10; ALU_Result_MEM = 32'h600;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0; MemRead_MEM = 1'b0;
    @(negedge Clk);
    chk("mid_rst_req", {31'b0, Dmem_Req}, 32'h0);
    chk("mid_rst_stall", {31'b0, Stall_MEM}, 32'h0);
    chk("mid_rst_be", {28'b0, Dmem_Be}, 32'h0);
    @(posedge Clk); #1;
    Dmem_Ack = 1'b1; Dmem_Rdata = 32'h76543210;
    @(posedge Clk); #1;
    Dmem_Ack = 1'b0;
    @(negedge Clk);
    chk("late_ack_valid", {31'b0, Load_Valid_MEM}, 32'h0);
    chk("late_ack_rdata", Read_Data_MEM, 32'h0);
    repeat (3) @(negedge Clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
